// File: rtl/smpl_rx.sv
// smpl_rx: far-end checker for the smpl toggle generator.
// Locks on a clean a/b stream, flags and counts protocol errors.
module smpl_rx #(
    parameter int SYNC_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] tgl_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCKN = CNT_W'(SYNC_LEN);
    localparam logic [CNT_W-1:0] SAT   = '1;

    state_t           state, state_n;
    logic             a_q, a_q_n;
    logic [CNT_W-1:0] sync_cnt, sync_cnt_n;
    logic [CNT_W-1:0] tgl_n, errc_n;
    logic [CNT_W-1:0] sync_inc;
    logic             good;

    assign good     = (a != a_q) && (b == a);
    assign sync_inc = sync_cnt + ONE;

    // State, sampled a and counters; rst wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= 1'b0;
            sync_cnt <= '0;
            tgl_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            a_q      <= a_q_n;
            sync_cnt <= sync_cnt_n;
            tgl_cnt  <= tgl_n;
            err_cnt  <= errc_n;
        end
    end

    // Next-state: check qualified samples, ERR always lasts one cycle.
    always_comb begin
        state_n    = state;
        a_q_n      = a_q;
        sync_cnt_n = sync_cnt;
        tgl_n      = tgl_cnt;
        errc_n     = err_cnt;
        if (en) begin
            a_q_n = a;
        end
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n    = SYNC;
                    sync_cnt_n = '0;
                end
            end
            SYNC: begin
                if (en) begin
                    if (good) begin
                        if (sync_inc == LOCKN) begin
                            state_n    = LOCKED;
                            sync_cnt_n = '0;
                        end else begin
                            sync_cnt_n = sync_inc;
                        end
                    end else begin
                        sync_cnt_n = '0;
                    end
                end
            end
            LOCKED: begin
                if (en) begin
                    if (good) begin
                        if (tgl_cnt != SAT) begin
                            tgl_n = tgl_cnt + ONE;
                        end
                    end else begin
                        state_n = ERR;
                        if (err_cnt != SAT) begin
                            errc_n = err_cnt + ONE;
                        end
                    end
                end
            end
            ERR: begin
                state_n    = SYNC;
                sync_cnt_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign locked = (state == LOCKED);
    assign err    = (state == ERR);

endmodule
